// File: rtl/button_rate_select.sv
// Debounced push-button front end: emits press/release/long-press pulses and a wrapping rate index.
// Optional macro BUTTON_AUTOREPEAT_EN steps the rate every REPEAT_CYCLES while the button is long-held.
module button_rate_select #(
  parameter int DEBOUNCE_CYCLES   = 270_000,
  parameter int LONG_PRESS_CYCLES = 27_000_000,
  parameter int REPEAT_CYCLES     = 6_750_000,
  parameter int RATE_COUNT        = 4,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Button_raw,
  output logic       Button_level,
  output logic       Press_pulse,
  output logic       Release_pulse,
  output logic       Long_press_pulse,
  output logic [1:0] Rate_select
);

  localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0);
  localparam int   STAB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int   HOLD_W     = $clog2(LONG_PRESS_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [1:0]        RATE_LAST = 2'(RATE_COUNT - 1);

  typedef enum logic [1:0] {RELEASED, PRESSED, LONG_HELD} state_t;

  state_t            state_reg;
  logic [1:0]        sync_reg;
  logic              level_reg;
  logic [STAB_W-1:0] stab_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [1:0]        rate_reg;
  logic              press_reg;
  logic              release_reg;
  logic              long_reg;
  logic              pressed_s;
  logic              flip;
  logic [1:0]        rate_next;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt_reg;
`endif

  // Pressed is 1 regardless of pin polarity once past the synchroniser.
  assign pressed_s = sync_reg[1] ^ IDLE_LEVEL;
  assign flip      = (pressed_s != level_reg) && (stab_cnt_reg == STAB_LAST);
  assign rate_next = (rate_reg == RATE_LAST) ? 2'd0 : rate_reg + 2'd1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_reg     <= {IDLE_LEVEL, IDLE_LEVEL};
      level_reg    <= 1'b0;
      stab_cnt_reg <= '0;
      hold_cnt_reg <= '0;
      rate_reg     <= 2'd0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      long_reg     <= 1'b0;
      state_reg    <= RELEASED;
`ifdef BUTTON_AUTOREPEAT_EN
      rep_cnt_reg  <= '0;
`endif
    end else begin
      sync_reg    <= {sync_reg[0], Button_raw};
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;

      if (pressed_s == level_reg) begin
        stab_cnt_reg <= '0;
      end else if (flip) begin
        stab_cnt_reg <= '0;
        level_reg    <= pressed_s;
      end else begin
        stab_cnt_reg <= stab_cnt_reg + STAB_W'(1);
      end

      case (state_reg)
        RELEASED: begin
          if (flip && pressed_s) begin
            press_reg    <= 1'b1;
            hold_cnt_reg <= '0;
            state_reg    <= PRESSED;
          end
        end
        PRESSED: begin
          // A release landing on the long-press edge counts as a short press.
          if (flip && !pressed_s) begin
            release_reg <= 1'b1;
            rate_reg    <= rate_next;
            state_reg   <= RELEASED;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            long_reg  <= 1'b1;
            state_reg <= LONG_HELD;
`ifdef BUTTON_AUTOREPEAT_EN
            rep_cnt_reg <= '0;
`endif
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        LONG_HELD: begin
          if (flip && !pressed_s) begin
            release_reg <= 1'b1;
            state_reg   <= RELEASED;
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (rep_cnt_reg == REP_LAST) begin
            rep_cnt_reg <= '0;
            rate_reg    <= rate_next;
            press_reg   <= 1'b1;
          end else begin
            rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
          end
`endif
        end
        default: state_reg <= RELEASED;
      endcase
    end
  end

  assign Button_level     = level_reg;
  assign Press_pulse      = press_reg;
  assign Release_pulse    = release_reg;
  assign Long_press_pulse = long_reg;
  assign Rate_select      = rate_reg;

endmodule

// File: tb/tb_button_rate_select.sv
// Bench for button_rate_select: directed scenarios plus random press/glitch sequences against an event-timing model.
module tb_button_rate_select;

  localparam int D    = 4;
  localparam int L    = 20;
  localparam int RP   = 8;
  localparam int RC   = 4;
  localparam int MAXT = 2048;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Button_raw = 1'b1;
  logic       Button_level;
  logic       Press_pulse;
  logic       Release_pulse;
  logic       Long_press_pulse;
  logic [1:0] Rate_select;

  int n_checks = 0;
  int n_fail   = 0;

  button_rate_select #(
    .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(RP),
    .RATE_COUNT(RC), .ACTIVE_LOW(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Button_raw(Button_raw),
    .Button_level(Button_level), .Press_pulse(Press_pulse),
    .Release_pulse(Release_pulse), .Long_press_pulse(Long_press_pulse),
    .Rate_select(Rate_select)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {Button_level, Press_pulse, Release_pulse, Long_press_pulse, Rate_select};
  endfunction

  function automatic logic [5:0] pack(bit lvl, bit pr, bit rl, bit lg, int rate);
    logic [1:0] r;
    r = 2'(rate);
    return {lvl, pr, rl, lg, r};
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    Button_raw = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
  endtask

  // Output vector order in FAIL lines: {level, press, release, long, rate[1:0]}.
  task automatic test_reset();
    Reset = 1'b1;
    Button_raw = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (obs() !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state got %b want %b", obs(), 6'b0);
    end
    Reset = 1'b0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      n_checks++;
      if (obs() !== 6'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset t=%0d got %b want %b", t, obs(), 6'b0);
      end
    end
    $display("reset: held 3 cycles, idle 50 cycles checked");
  endtask

  task automatic test_press_latency();
    logic [5:0] e;
    do_reset();
    Button_raw = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      e = pack(t >= 6, t == 6, 1'b0, 1'b0, 0);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL press_latency t=%0d got %b want %b", t, obs(), e);
      end
    end
    Button_raw = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      e = pack(t < 6, 1'b0, t == 6, 1'b0, (t >= 6) ? 1 : 0);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL release_latency t=%0d got %b want %b", t, obs(), e);
      end
    end
    $display("press_latency: press and release each 6 cycles after raw edge");
  endtask

  task automatic test_glitch();
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      Button_raw = 1'b0;
      for (int t = 1; t <= w; t++) begin
        tick();
        n_checks++;
        if (obs() !== 6'b0) begin
          n_fail++;
          $display("FAIL glitch_low w=%0d t=%0d got %b want %b", w, t, obs(), 6'b0);
        end
      end
      Button_raw = 1'b1;
      for (int t = 1; t <= 8; t++) begin
        tick();
        n_checks++;
        if (obs() !== 6'b0) begin
          n_fail++;
          $display("FAIL glitch_high w=%0d t=%0d got %b want %b", w, t, obs(), 6'b0);
        end
      end
      $display("glitch: %0d-cycle low pulse ignored", w);
    end
  endtask

  task automatic test_rate_cycle();
    int rate;
    int nxt;
    logic [5:0] e;
    do_reset();
    rate = 0;
    for (int p = 0; p < 4; p++) begin
      nxt = (rate + 1) % RC;
      Button_raw = 1'b0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        e = pack(t >= 6, t == 6, 1'b0, 1'b0, rate);
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL rate_press p=%0d t=%0d got %b want %b", p, t, obs(), e);
        end
      end
      Button_raw = 1'b1;
      for (int t = 1; t <= 10; t++) begin
        tick();
        e = pack(t < 6, 1'b0, t == 6, 1'b0, (t >= 6) ? nxt : rate);
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL rate_release p=%0d t=%0d got %b want %b", p, t, obs(), e);
        end
      end
      rate = nxt;
      $display("rate_cycle: short press %0d -> rate %0d", p, rate);
    end
  endtask

  task automatic test_long_press();
    logic [5:0] e;
    bit pr;
    int rate;
    do_reset();
    for (int t = 1; t <= 52; t++) begin
      Button_raw = (t <= 40) ? 1'b0 : 1'b1;
      tick();
      pr = (t == 6);
      rate = 0;
`ifdef BUTTON_AUTOREPEAT_EN
      pr = pr || (t == 34) || (t == 42);
      rate = (t >= 42) ? 2 : ((t >= 34) ? 1 : 0);
`endif
      e = pack((t >= 6) && (t < 46), pr, t == 46, t == 26, rate);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL long_press t=%0d got %b want %b", t, obs(), e);
      end
    end
    $display("long_press: 40-cycle hold, long pulse 20 cycles after press");
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] e;
    do_reset();
    Button_raw = 1'b0;
    repeat (10) tick();
    Button_raw = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (Rate_select !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_hold_prefix_rate got %0d want 1", Rate_select);
    end
    Button_raw = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      e = pack(t >= 6, t == 6, 1'b0, 1'b0, 1);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL mid_hold_before t=%0d got %b want %b", t, obs(), e);
      end
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++;
    if (obs() !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_hold_reset got %b want %b", obs(), 6'b0);
    end
    for (int t = 1; t <= 8; t++) begin
      tick();
      e = pack(t >= 6, t == 6, 1'b0, 1'b0, 0);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL mid_hold_after t=%0d got %b want %b", t, obs(), e);
      end
    end
    Button_raw = 1'b1;
    repeat (10) tick();
    $display("reset_mid_hold: outputs cleared, press re-accepted 6 cycles later");
  endtask

  // Model works on whole raw segments: a segment differing from the debounced level
  // flips it D+1 cycles after its first sample iff it lasts at least D samples.
  task automatic test_random();
    int  seg_len[$];
    bit  seg_val[$];
    int  flip_t[$];
    bit  raw_at[MAXT];
    bit  lvl[MAXT];
    bit  pr[MAXT];
    bit  rl[MAXT];
    bit  lg[MAXT];
    bit  inc[MAXT];
    bit  v;
    bit  level;
    int  k;
    int  tend;
    int  pt;
    int  rt;
    int  rate;
    logic [5:0] e;

    for (int i = 0; i < MAXT; i++) begin
      raw_at[i] = 1'b1; lvl[i] = 0; pr[i] = 0; rl[i] = 0; lg[i] = 0; inc[i] = 0;
    end
    v = 1'b1;
    for (int i = 0; i < 30; i++) begin
      seg_val.push_back(v);
      seg_len.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 45)));
      v = !v;
    end
    seg_len[29] = seg_len[29] + 40;

    level = 1'b0;
    k = 1;
    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < seg_len[i]; j++) raw_at[k + j] = !seg_val[i];
      if ((seg_val[i] != level) && (seg_len[i] >= D)) begin
        flip_t.push_back(k + 1 + D);
        level = seg_val[i];
      end
      $display("random: segment %0d pressed=%0d len=%0d", i, seg_val[i], seg_len[i]);
      k = k + seg_len[i];
    end
    tend = k - 1;

    for (int i = 0; i + 1 < flip_t.size(); i += 2) begin
      pt = flip_t[i];
      rt = flip_t[i + 1];
      for (int t = pt; t < rt; t++) lvl[t] = 1'b1;
      pr[pt] = 1'b1;
      rl[rt] = 1'b1;
      if (rt <= pt + L) begin
        inc[rt] = 1'b1;
      end else begin
        lg[pt + L] = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
        for (int t = pt + L + RP; t < rt; t += RP) begin
          pr[t]  = 1'b1;
          inc[t] = 1'b1;
        end
`endif
      end
    end

    do_reset();
    rate = 0;
    for (int t = 1; t <= tend; t++) begin
      Button_raw = raw_at[t];
      tick();
      if (inc[t]) rate = (rate + 1) % RC;
      e = pack(lvl[t], pr[t], rl[t], lg[t], rate);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL random t=%0d got %b want %b", t, obs(), e);
      end
    end
    $display("random: %0d cycles, %0d debounced edges", tend, flip_t.size());
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_rate_cycle();
    test_long_press();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
